// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream into big-endian 32-bit words, writes
// them into instruction memory, and releases the core once the checksum matches.
`timescale 1ns/1ps
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // state    | meaning
  // S_IDLE   | waiting for start after reset, core held
  // S_HDR_HI | expecting count[15:8]
  // S_HDR_LO | expecting count[7:0], range check on the full count
  // S_DATA   | collecting the 4 bytes of the current word
  // S_WRITE  | one-cycle write strobe of the assembled word
  // S_CHECK  | expecting the checksum byte
  // S_DONE   | load verified, core released
  // S_ERROR  | session aborted, core held
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  csum_q;
  logic [31:0] word_q;
  logic [31:0] addr_q;

  logic        xfer;
  logic        session_open;
  logic [15:0] count_full;
  logic [15:0] word_idx_next;

  assign byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer          = byte_valid && byte_ready;
  assign session_open  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                   (state_q == S_ERROR));
  assign count_full    = {count_q[15:8], byte_data};
  assign word_idx_next = word_idx_q + 16'd1;

  assign wr_en    = (state_q == S_WRITE);
  assign wr_addr  = addr_q;
  assign wr_data  = word_q;
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);
  assign cpu_hold = (state_q != S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_HDR_HI;
      S_HDR_HI: if (xfer) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (xfer) begin
          if (count_full > MAX_W)       state_d = S_ERROR;
          else if (count_full == 16'd0) state_d = S_CHECK;
          else                          state_d = S_DATA;
        end
      end
      S_DATA:  if (xfer && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE: state_d = (word_idx_next == count_q) ? S_CHECK : S_DATA;
      S_CHECK: if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
    end else if (session_open) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      case (state_q)
        S_HDR_HI: if (xfer) count_q[15:8] <= byte_data;
        S_HDR_LO: if (xfer) count_q[7:0]  <= byte_data;
        S_DATA: begin
          if (xfer) begin
            word_q     <= {word_q[23:0], byte_data};
            csum_q     <= csum_q ^ byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        S_WRITE: begin
          // address advances after the strobe so wr_addr is BASE + 4k during it
          word_idx_q <= word_idx_next;
          addr_q     <= addr_q + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, writes, checksum, range limit,
// empty frames and asynchronous reset during a word.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wa_q.delete(); wd_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready got=%b want=1", byte_ready);
    end
  endtask

  // returns #1 after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int t;
    @(negedge clock);
    byte_valid = 1'b0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clock);
    byte_valid = 1'b1; byte_data = b; t = 0;
    while (byte_ready !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    if (byte_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h ready=%b want=1", b, byte_ready);
    end
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({byte_ready, wr_en, cpu_hold, done, error} !== 5'b00100 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h want 0 0 1 0 0 0 0",
               byte_ready, wr_en, cpu_hold, done, error, wr_addr, wr_data);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
    checks++;
    if (wr_en !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL early_write got we=%b hold=%b want 0 1", wr_en, cpu_hold);
    end
    send_byte(8'h05, 0);
    checks++;
    if (wr_en !== 1'b1 || byte_ready !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h2008_0005) begin
      errors++;
      $display("FAIL single_write got we=%b rdy=%b addr=%h data=%h want 1 0 00000000 20080005",
               wr_en, byte_ready, wr_addr, wr_data);
    end
    // checksum = 20^08^00^05
    send_byte(8'h2D, 0);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || wa_q.size() != 1) begin
      errors++;
      $display("FAIL single_done got done=%b hold=%b err=%b writes=%0d want 1 0 0 1",
               done, cpu_hold, error, wa_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  frame [0:14];
    logic [31:0] exp_w [0:2];
    frame = '{8'h00, 8'h03,
              8'h01, 8'h23, 8'h45, 8'h67,
              8'h89, 8'hAB, 8'hCD, 8'hEF,
              8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h22};
    exp_w = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    for (int i = 0; i < 15; i++) send_byte(frame[i], 3);
    checks++;
    if (wa_q.size() != 3) begin
      errors++; $display("FAIL bp_write_count got=%0d want=3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[i] !== 32'(4 * i) || wd_q[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL bp_write%0d got addr=%h data=%h want addr=%h data=%h",
                   i, wa_q[i], wd_q[i], 32'(4 * i), exp_w[i]);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL bp_done got done=%b err=%b want 1 0", done, error);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] frame [0:6];
    frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h0C};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || wa_q.size() != 1) begin
      errors++;
      $display("FAIL bad_csum got err=%b done=%b hold=%b writes=%0d want 1 0 1 1",
               error, done, cpu_hold, wa_q.size());
    end
    frame[6] = 8'h2D;
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(frame[i], 1);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL recover_done got done=%b err=%b want 1 0", done, error);
    end
  endtask

  task automatic test_oversize();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    checks++;
    if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL oversize got err=%b rdy=%b hold=%b want 1 0 1", error, byte_ready, cpu_hold);
    end
    byte_valid = 1'b1; byte_data = 8'h11;
    repeat (6) @(negedge clock);
    byte_valid = 1'b0;
    checks++;
    if (wa_q.size() != 0 || byte_ready !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL oversize_hold got writes=%0d rdy=%b err=%b want 0 0 1",
               wa_q.size(), byte_ready, error);
    end
  endtask

  task automatic test_empty();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL empty_ok got done=%b err=%b writes=%0d want 1 0 0", done, error, wa_q.size());
    end
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL empty_bad got err=%b done=%b writes=%0d want 1 0 0", error, done, wa_q.size());
    end
  endtask

  task automatic test_reset_mid_word();
    int seen_ready;
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h20, 0); send_byte(8'h08, 0);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({byte_ready, wr_en, cpu_hold, done, error} !== 5'b00100 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h want 0 0 1 0 0 0 0",
               byte_ready, wr_en, cpu_hold, done, error, wr_addr, wr_data);
    end
    @(negedge clock); reset = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h05;
    seen_ready = 0;
    repeat (8) begin
      @(negedge clock);
      if (byte_ready === 1'b1) seen_ready++;
    end
    byte_valid = 1'b0;
    checks++;
    if (seen_ready != 0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL reset_needs_start got ready_cycles=%0d writes=%0d want 0 0", seen_ready, wa_q.size());
    end
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_byte(8'h2D, 0);
    checks++;
    if (done !== 1'b1 || wa_q.size() != 1) begin
      errors++; $display("FAIL reset_reload got done=%b writes=%0d want 1 1", done, wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h2008_0005) begin
        errors++;
        $display("FAIL reset_reload_word got addr=%h data=%h want 00000000 20080005", wa_q[0], wd_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
